banco_filtros_tdm: RTL

- Parametrised successor to the fixed three-band equaliser filter bank.
- Computes `bandas` parallel bands; each band is a cascade of `etapas` Direct-Form-I biquads in signed Q(magnitud).(fraccion) fixed point.
- A single time-multiplexed multiply-accumulate unit does all the arithmetic; coefficients are runtime-loadable rather than hard-coded.
- Sits between the audio sample source and the per-band gain/mixing stage.

---
 rtl/banco_filtros_tdm.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/banco_filtros_tdm.sv
// Bank of `bandas` cascades of `etapas` Direct-Form-I biquads sharing one multiply-accumulate unit.
// Coefficients are runtime-loadable from IDLE; each band's result lands in its ykbandas slot.
module banco_filtros_tdm #(
    parameter int ancho    = 25,
    parameter int magnitud = 8,
    parameter int fraccion = 16,
    parameter int bandas   = 3,
    parameter int etapas   = 2,
    localparam int AW      = $clog2(bandas*etapas*5)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [ancho-1:0] func_entrada,
    input  logic                    limpiar,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [ancho-1:0] coef_data,
    output logic                    coef_rechazo,
    output logic [bandas*ancho-1:0] ykbandas,
    output logic                    sal_valida,
    output logic                    ocupado,
    output logic                    sobrecarga,
    output logic                    saturacion
);
    localparam int NC   = bandas*etapas*5;
    localparam int NS   = bandas*etapas;
    localparam int PW   = 2*ancho;
    localparam int ACCW = 2*ancho+3;
    localparam int SIW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int BIW  = (bandas > 1) ? $clog2(bandas) : 1;
    localparam int EIW  = (etapas > 1) ? $clog2(etapas) : 1;

    localparam logic signed [ancho-1:0] UNO  = {{(ancho-1){1'b0}}, 1'b1} << fraccion;
    localparam logic signed [ACCW-1:0]  REDO = {{(ACCW-1){1'b0}}, 1'b1} << (fraccion-1);
    localparam logic signed [ACCW-1:0]  SMAX = {{(ACCW-magnitud-fraccion){1'b0}}, {(magnitud+fraccion){1'b1}}};
    localparam logic signed [ACCW-1:0]  SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} estado_t;

    estado_t                 estado_q, estado_d;
    logic [2:0]              k_q;
    logic [BIW-1:0]          banda_q;
    logic [EIW-1:0]          etapa_q;
    logic [SIW-1:0]          sidx_q;
    logic signed [ancho-1:0] muestra_q, xact_q;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [ancho-1:0] coef_q [NC];
    logic signed [ancho-1:0] x1_q [NS];
    logic signed [ancho-1:0] x2_q [NS];
    logic signed [ancho-1:0] y1_q [NS];
    logic signed [ancho-1:0] y2_q [NS];
    logic signed [ancho-1:0] yk_q [bandas];
    logic                    sal_valida_q, rechazo_q, sobrecarga_q, saturacion_q;

    logic                    ultima_etapa_s, ultima_banda_s, dir_valida_s, recorte_s;
    logic [AW-1:0]           cidx_s;
    logic signed [ancho-1:0] coef_act_s, dato_s, r_sat_s;
    logic [PW-1:0]           prod_s;
    logic signed [ACCW-1:0]  prodx_s, acc_d_s, suma_s, rnd_s;

    assign ultima_etapa_s = (etapa_q == EIW'(etapas-1));
    assign ultima_banda_s = (banda_q == BIW'(bandas-1));
    assign dir_valida_s   = (32'(coef_addr) < NC);
    assign cidx_s         = AW'(32'(sidx_q) * 32'd5 + 32'(k_q));
    assign coef_act_s     = coef_q[cidx_s];

    // Operand select, product and rounding/saturation of the finished accumulator
    always_comb begin
        case (k_q)
            3'd0:    dato_s = xact_q;
            3'd1:    dato_s = x1_q[sidx_q];
            3'd2:    dato_s = x2_q[sidx_q];
            3'd3:    dato_s = y1_q[sidx_q];
            default: dato_s = y2_q[sidx_q];
        endcase
        // Sign-extended operands make the low PW bits of the unsigned product the signed product
        prod_s  = {{ancho{coef_act_s[ancho-1]}}, coef_act_s} * {{ancho{dato_s[ancho-1]}}, dato_s};
        prodx_s = {{(ACCW-PW){prod_s[PW-1]}}, prod_s};
        if (k_q < 3'd3) begin
            acc_d_s = acc_q + prodx_s;
        end else begin
            acc_d_s = acc_q - prodx_s;
        end
        suma_s = acc_q + REDO;
        rnd_s  = suma_s >>> fraccion;
        if (rnd_s > SMAX) begin
            r_sat_s   = SMAX[ancho-1:0];
            recorte_s = 1'b1;
        end else if (rnd_s < SMIN) begin
            r_sat_s   = SMIN[ancho-1:0];
            recorte_s = 1'b1;
        end else begin
            r_sat_s   = rnd_s[ancho-1:0];
            recorte_s = 1'b0;
        end
    end

    // Sequencer next state
    always_comb begin
        estado_d = estado_q;
        if (limpiar) begin
            estado_d = IDLE;
        end else begin
            case (estado_q)
                IDLE:    estado_d = en ? MAC : IDLE;
                MAC:     estado_d = (k_q == 3'd4) ? WB : MAC;
                WB:      estado_d = (ultima_etapa_s && ultima_banda_s) ? DONE : MAC;
                DONE:    estado_d = IDLE;
                default: estado_d = IDLE;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado_q <= IDLE;
        else       estado_q <= estado_d;
    end

    // Coefficient store: passthrough after reset, writable only while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) coef_q[i] <= (i % 5 == 0) ? UNO : '0;
            rechazo_q <= 1'b0;
        end else begin
            rechazo_q <= 1'b0;
            if (coef_we) begin
                if (estado_q == IDLE && dir_valida_s) coef_q[coef_addr] <= coef_data;
                else                                  rechazo_q <= 1'b1;
            end
        end
    end

    // Datapath: capture, accumulate, write-back of history and band outputs, sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= 3'd0; banda_q <= '0; etapa_q <= '0; sidx_q <= '0;
            muestra_q <= '0; xact_q <= '0; acc_q <= '0;
            for (int i = 0; i < NS; i++) begin
                x1_q[i] <= '0; x2_q[i] <= '0; y1_q[i] <= '0; y2_q[i] <= '0;
            end
            for (int b = 0; b < bandas; b++) yk_q[b] <= '0;
            sal_valida_q <= 1'b0; sobrecarga_q <= 1'b0; saturacion_q <= 1'b0;
        end else if (limpiar) begin
            k_q <= 3'd0; banda_q <= '0; etapa_q <= '0; sidx_q <= '0; acc_q <= '0;
            for (int i = 0; i < NS; i++) begin
                x1_q[i] <= '0; x2_q[i] <= '0; y1_q[i] <= '0; y2_q[i] <= '0;
            end
            for (int b = 0; b < bandas; b++) yk_q[b] <= '0;
            sal_valida_q <= 1'b0; sobrecarga_q <= 1'b0; saturacion_q <= 1'b0;
        end else begin
            sal_valida_q <= (estado_q == DONE);
            if (en && estado_q != IDLE) sobrecarga_q <= 1'b1;
            case (estado_q)
                IDLE: begin
                    if (en) begin
                        muestra_q <= func_entrada; xact_q <= func_entrada; acc_q <= '0;
                        k_q <= 3'd0; banda_q <= '0; etapa_q <= '0; sidx_q <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d_s;
                    k_q   <= (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
                end
                WB: begin
                    x2_q[sidx_q] <= x1_q[sidx_q];
                    x1_q[sidx_q] <= xact_q;
                    y2_q[sidx_q] <= y1_q[sidx_q];
                    y1_q[sidx_q] <= r_sat_s;
                    if (recorte_s) saturacion_q <= 1'b1;
                    acc_q  <= '0;
                    sidx_q <= sidx_q + 1'b1;
                    if (ultima_etapa_s) begin
                        yk_q[banda_q] <= r_sat_s;
                        etapa_q <= '0;
                        banda_q <= banda_q + 1'b1;
                        xact_q  <= muestra_q;
                    end else begin
                        etapa_q <= etapa_q + 1'b1;
                        xact_q  <= r_sat_s;
                    end
                end
                DONE:    acc_q <= '0;
                default: acc_q <= '0;
            endcase
        end
    end

    // Pack band results, band 0 in the LSBs
    always_comb begin
        ykbandas = '0;
        for (int b = 0; b < bandas; b++) ykbandas[b*ancho +: ancho] = yk_q[b];
    end

    assign ocupado      = (estado_q != IDLE);
    assign sal_valida   = sal_valida_q;
    assign coef_rechazo = rechazo_q;
    assign sobrecarga   = sobrecarga_q;
    assign saturacion   = saturacion_q;
endmodule
